// File: rtl/lcd_rect_fill.sv
// lcd_rect_fill: address-window and pixel sequencer feeding a byte-level SPI TX
// stage of an ST7735-class LCD. Opens a CS frame, sends CASET/RASET/RAMWR and
// then streams one RGB565 colour per pixel, one byte in flight at a time.
module lcd_rect_fill #(
  parameter int CS_GAP = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  x0_i,
  input  logic [7:0]  x1_i,
  input  logic [7:0]  y0_i,
  input  logic [7:0]  y1_i,
  input  logic [15:0] color_i,
  input  logic        tx_done_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        tx_dc_o,
  output logic        cs_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_ISSUE, S_WAIT, S_FINISH, S_GAP
  } state_e;

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [3:0] HDR_LAST = 4'd10;  // index of RAMWR in the header
  localparam logic [3:0] HDR_PIX  = 4'd11;  // header done, streaming pixels

  state_e          state_q;
  logic [7:0]      x0_q, x1_q, y0_q, y1_q;
  logic [15:0]     color_q;
  logic [16:0]     pix_cnt_q;
  logic [3:0]      hdr_idx_q;
  logic            hi_sent_q;
  logic            abort_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_start_q, tx_dc_q, cs_q, busy_q, done_q, err_q;

  logic            win_ok;
  logic [8:0]      w_x, w_y;
  logic [16:0]     pix_cnt_d;
  logic [16:0]     pix_cnt_dec;
  logic [3:0]      hdr_nxt;
  logic [7:0]      hdr_data_d;
  logic            hdr_dc_d;

  // Window validation, pixel count and the next header byte after the one in flight.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hdr_data_d  = 8'h2A;
    hdr_dc_d    = 1'b0;
    win_ok      = (x1_i >= x0_i) && (y1_i >= y0_i);
    w_x         = {1'b0, x1_i} - {1'b0, x0_i} + 9'd1;
    w_y         = {1'b0, y1_i} - {1'b0, y0_i} + 9'd1;
    pix_cnt_d   = 17'(w_x) * 17'(w_y);  // up to 256*256 = 65536 fits in 17 bits
    pix_cnt_dec = pix_cnt_q - 17'd1;
    hdr_nxt     = hdr_idx_q + 4'd1;
    case (hdr_nxt)
      4'd1:    begin hdr_data_d = 8'h00; hdr_dc_d = 1'b1; end
      4'd2:    begin hdr_data_d = x0_q;  hdr_dc_d = 1'b1; end
      4'd3:    begin hdr_data_d = 8'h00; hdr_dc_d = 1'b1; end
      4'd4:    begin hdr_data_d = x1_q;  hdr_dc_d = 1'b1; end
      4'd5:    begin hdr_data_d = 8'h2B; hdr_dc_d = 1'b0; end
      4'd6:    begin hdr_data_d = 8'h00; hdr_dc_d = 1'b1; end
      4'd7:    begin hdr_data_d = y0_q;  hdr_dc_d = 1'b1; end
      4'd8:    begin hdr_data_d = 8'h00; hdr_dc_d = 1'b1; end
      4'd9:    begin hdr_data_d = y1_q;  hdr_dc_d = 1'b1; end
      4'd10:   begin hdr_data_d = 8'h2C; hdr_dc_d = 1'b0; end
      default: begin hdr_data_d = 8'h2A; hdr_dc_d = 1'b0; end
    endcase
  end

  // Frame FSM; all interface outputs are registered here.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      pix_cnt_q  <= '0;
      hdr_idx_q  <= '0;
      hi_sent_q  <= 1'b0;
      abort_q    <= 1'b0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_dc_q    <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (win_ok) begin
              x0_q      <= x0_i;
              x1_q      <= x1_i;
              y0_q      <= y0_i;
              y1_q      <= y1_i;
              color_q   <= color_i;
              pix_cnt_q <= pix_cnt_d;
              hdr_idx_q <= '0;
              hi_sent_q <= 1'b0;
              abort_q   <= 1'b0;
              busy_q    <= 1'b1;
              cs_q      <= 1'b0;
              state_q   <= S_CS_SETUP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CS_SETUP: begin
          if (abort_i) begin
            cs_q      <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end else begin
            tx_data_q  <= 8'h2A;
            tx_dc_q    <= 1'b0;
            tx_start_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The byte is already launched; an abort here only stops the next one.
          if (abort_i) abort_q <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (abort_i) abort_q <= 1'b1;
          if (tx_done_i) begin
            if (abort_i || abort_q) begin
              cs_q      <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end else if (hdr_idx_q != HDR_PIX) begin
              if (hdr_idx_q == HDR_LAST) begin
                tx_data_q <= color_q[15:8];
                tx_dc_q   <= 1'b1;
                hi_sent_q <= 1'b1;
              end else begin
                tx_data_q <= hdr_data_d;
                tx_dc_q   <= hdr_dc_d;
              end
              hdr_idx_q  <= hdr_nxt;
              tx_start_q <= 1'b1;
              state_q    <= S_ISSUE;
            end else if (hi_sent_q) begin
              tx_data_q  <= color_q[7:0];
              tx_dc_q    <= 1'b1;
              hi_sent_q  <= 1'b0;
              tx_start_q <= 1'b1;
              state_q    <= S_ISSUE;
            end else begin
              // A low byte just finished: one pixel fewer remains.
              pix_cnt_q <= pix_cnt_dec;
              if (pix_cnt_dec == 17'd0) begin
                cs_q    <= 1'b1;
                done_q  <= 1'b1;
                state_q <= S_FINISH;
              end else begin
                tx_data_q  <= color_q[15:8];
                tx_dc_q    <= 1'b1;
                hi_sent_q  <= 1'b1;
                tx_start_q <= 1'b1;
                state_q    <= S_ISSUE;
              end
            end
          end
        end
        S_FINISH: begin
          gap_cnt_q <= '0;
          state_q   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign tx_dc_o    = tx_dc_q;
  assign cs_o       = cs_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_lcd_rect_fill.sv
// Directed bench for lcd_rect_fill: an SPI TX stand-in answers each tx_start
// with tx_done 16 cycles later, and a monitor logs every launched byte.
module tb_lcd_rect_fill;

  localparam int CS_GAP = 2;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  x0_i = '0, x1_i = '0, y0_i = '0, y1_i = '0;
  logic [15:0] color_i = '0;
  logic        tx_done_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o, tx_dc_o, cs_o, busy_o, done_o, err_o;

  lcd_rect_fill #(.CS_GAP(CS_GAP)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i), .color_i(color_i),
    .tx_done_i(tx_done_i), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
    .tx_dc_o(tx_dc_o), .cs_o(cs_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Monitor state: cumulative counts, tests look at deltas.
  logic [8:0] seen_q[$];   // {dc, data} per tx_start
  logic [8:0] exp_q[$];
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, resp_cnt = 0, resp_done = 0;
  int cs_rise = 0, cs_busy_hi = 0, busy_cyc = 0, cs_low_cyc = 0, bad_cs_tx = 0;
  int rise_at_done = 0;
  logic cs_prev = 1'b1;

  // SPI TX model plus monitor, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_ni) begin
      resp_cnt  = 0;
      tx_done_i = 1'b0;
      cs_prev   = 1'b1;
    end else begin
      tx_done_i = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          tx_done_i = 1'b1;
          resp_done++;
        end
      end
      if (tx_start_o) begin
        seen_q.push_back({tx_dc_o, tx_data_o});
        start_cnt++;
        if (cs_o) bad_cs_tx++;
        resp_cnt = 16;
      end
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (busy_o) busy_cyc++;
      if (!cs_o) cs_low_cyc++;
      if (cs_o && busy_o) cs_busy_hi++;
      if (cs_o && !cs_prev) begin
        cs_rise++;
        rise_at_done = resp_done;
      end
      cs_prev = cs_o;
    end
  end

  task automatic pulse_start(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [15:0] col);
    @(negedge clk);
    x0_i = a0; x1_i = a1; y0_i = b0; y1_i = b1; color_i = col;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1; break; end
    end
    #1;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy_o, budget);
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (start_cnt >= target) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: tx_start count %0d, required %0d", name, start_cnt, target);
    end
  endtask

  // Expected-stream builders (bench-side model of the byte sequence).
  task automatic exp_header(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, a0});    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, a1});    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, b0});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, b1});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  task automatic exp_pixels(input logic [15:0] col, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, col[15:8]});
      exp_q.push_back({1'b1, col[7:0]});
    end
  endtask

  task automatic compare_stream(input int base, input string name);
    total++;
    if (seen_q.size() - base != exp_q.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, seen_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (seen_q[base + i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s_byte%0d: got dc/data %h, required %h", name, i, seen_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({cs_o, tx_start_o, tx_dc_o, tx_data_o, busy_o, done_o, err_o} !== {3'b100, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset_outputs: got cs/start/dc/data/busy/done/err %b, required 100_00000000_000",
               {cs_o, tx_start_o, tx_dc_o, tx_data_o, busy_o, done_o, err_o});
    end
    @(negedge clk);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_pixel;
    int b = seen_q.size();
    int d0 = done_cnt, r0 = cs_rise, g0 = cs_busy_hi, x0 = bad_cs_tx;
    pulse_start(8'd5, 8'd5, 8'd7, 8'd7, 16'hF800);
    wait_idle(2000, "single");
    exp_q = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B,
              9'h100, 9'h107, 9'h100, 9'h107, 9'h02C, 9'h1F8, 9'h100};
    compare_stream(b, "single");
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL single_done: got %0d done pulses, required 1", done_cnt - d0);
    end
    total++;
    if (cs_rise - r0 != 1 || bad_cs_tx != x0) begin
      bad++; $display("FAIL single_cs: got %0d cs rises / %0d bytes with cs high, required 1 / 0",
                      cs_rise - r0, bad_cs_tx - x0);
    end
    total++;
    if (cs_busy_hi - g0 != CS_GAP + 1) begin
      bad++; $display("FAIL single_gap: got %0d cs-high busy cycles, required %0d", cs_busy_hi - g0, CS_GAP + 1);
    end
  endtask

  task automatic test_window_2x3;
    int b = seen_q.size();
    int d0 = done_cnt;
    pulse_start(8'd0, 8'd1, 8'd0, 8'd2, 16'h07E0);
    wait_idle(2000, "win2x3");
    exp_header(8'd0, 8'd1, 8'd0, 8'd2);
    exp_pixels(16'h07E0, 6);
    compare_stream(b, "win2x3");
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL win2x3_done: got %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_invalid;
    int s0 = start_cnt, e0 = err_cnt, bc0 = busy_cyc, cl0 = cs_low_cyc;
    pulse_start(8'd9, 8'd3, 8'd0, 8'd0, 16'h1234);
    repeat (4) @(negedge clk);
    pulse_start(8'd0, 8'd0, 8'd4, 8'd2, 16'h1234);
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (err_cnt - e0 != 2) begin
      bad++; $display("FAIL invalid_err: got %0d err cycles, required 2", err_cnt - e0);
    end
    total++;
    if (start_cnt != s0 || busy_cyc != bc0 || cs_low_cyc != cl0) begin
      bad++; $display("FAIL invalid_quiet: got tx_start %0d busy %0d cs-low %0d cycles, required 0 0 0",
                      start_cnt - s0, busy_cyc - bc0, cs_low_cyc - cl0);
    end
  endtask

  task automatic test_back_to_back;
    int b = seen_q.size();
    int d0 = done_cnt;
    pulse_start(8'd0, 8'd1, 8'd0, 8'd2, 16'h07E0);
    wait_starts(start_cnt + 3, 200, "b2b");
    pulse_start(8'd10, 8'd20, 8'd30, 8'd40, 16'hABCD);
    x0_i = 8'd77; color_i = 16'h5555;
    wait_idle(2000, "b2b");
    exp_header(8'd0, 8'd1, 8'd0, 8'd2);
    exp_pixels(16'h07E0, 6);
    compare_stream(b, "b2b");
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL b2b_done: got %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_abort;
    int s0 = start_cnt, d0 = done_cnt, rd0 = resp_done, g0 = cs_busy_hi;
    pulse_start(8'd0, 8'd1, 8'd0, 8'd2, 16'h07E0);
    wait_starts(s0 + 16, 600, "abort");   // byte 16 = 3rd pixel high byte
    repeat (3) @(negedge clk);
    abort_i = 1'b1;
    wait_idle(200, "abort");
    abort_i = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    total++;
    if (start_cnt - s0 != 16) begin
      bad++; $display("FAIL abort_starts: got %0d tx_start pulses, required 16", start_cnt - s0);
    end
    total++;
    if (done_cnt != d0) begin
      bad++; $display("FAIL abort_done: got %0d done pulses, required 0", done_cnt - d0);
    end
    total++;
    if (rise_at_done - rd0 != 16 || cs_o !== 1'b1) begin
      bad++; $display("FAIL abort_cs: cs rose after %0d completed bytes (cs now %b), required 16 (1)",
                      rise_at_done - rd0, cs_o);
    end
    total++;
    if (cs_busy_hi - g0 != CS_GAP) begin
      bad++; $display("FAIL abort_gap: got %0d cs-high busy cycles, required %0d", cs_busy_hi - g0, CS_GAP);
    end
  endtask

  task automatic test_abort_setup;
    int s0 = start_cnt, d0 = done_cnt;
    @(negedge clk);
    abort_i = 1'b1;
    pulse_start(8'd1, 8'd2, 8'd3, 8'd4, 16'hFFFF);
    wait_idle(50, "abort_setup");
    abort_i = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (start_cnt != s0 || done_cnt != d0 || cs_o !== 1'b1) begin
      bad++; $display("FAIL abort_setup: got tx_start %0d done %0d cs %b, required 0 0 1",
                      start_cnt - s0, done_cnt - d0, cs_o);
    end
  endtask

  task automatic test_full_row;
    int b = seen_q.size();
    int d0 = done_cnt;
    pulse_start(8'd0, 8'd255, 8'd0, 8'd0, 16'h001F);
    wait_idle(12000, "fullrow");
    exp_header(8'd0, 8'd255, 8'd0, 8'd0);
    exp_pixels(16'h001F, 256);
    compare_stream(b, "fullrow");
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL fullrow_done: got %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int b;
    int d0;
    pulse_start(8'd5, 8'd5, 8'd7, 8'd7, 16'hF800);
    wait_starts(start_cnt + 4, 200, "midrst");
    #2;
    reset_ni = 1'b0;
    #1;
    total++;
    if ({cs_o, tx_start_o, tx_dc_o, tx_data_o, busy_o, done_o, err_o} !== {3'b100, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL midrst_outputs: got cs/start/dc/data/busy/done/err %b, required 100_00000000_000",
               {cs_o, tx_start_o, tx_dc_o, tx_data_o, busy_o, done_o, err_o});
    end
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    repeat (30) @(negedge clk);
    b  = seen_q.size();
    d0 = done_cnt;
    pulse_start(8'd5, 8'd5, 8'd7, 8'd7, 16'hF800);
    wait_idle(2000, "midrst");
    exp_header(8'd5, 8'd5, 8'd7, 8'd7);
    exp_pixels(16'hF800, 1);
    compare_stream(b, "midrst");
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL midrst_done: got %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset;
    test_single_pixel;
    test_window_2x3;
    test_invalid;
    test_back_to_back;
    test_abort;
    test_abort_setup;
    test_full_row;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
